// File: rtl/booth_feeder_pkg.sv
// Shared constants and FSM encoding for the booth_mult operand feeder.
package booth_feeder_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

endpackage

// File: rtl/booth_feeder_op_fifo.sv
// Operand-pair FIFO: power-of-two depth, registered count and ready flag.
module op_fifo
  import booth_feeder_pkg::*;
#(
  parameter int unsigned DW    = 2 * DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [DW-1:0]          wdata_i,
  output logic [DW-1:0]          head_c,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   ready_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic          ready_q, ready_d;
  logic          push_ok, pop_ok;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    push_ok = push_i && ready_q;
    pop_ok  = pop_i && (count_q != '0);
    wr_d    = push_ok ? wr_q + AW'(1) : wr_q;
    rd_d    = pop_ok  ? rd_q + AW'(1) : rd_q;
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    ready_d = (count_d < CW'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ready_q <= 1'b1;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      ready_q <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= wdata_i;
  end

  assign head_c  = mem_q[rd_q];
  assign count_o = count_q;
  assign ready_o = ready_q;

endmodule

// File: rtl/booth_feeder.sv
// Feeds queued operand pairs to booth_mult one at a time and holds each
// product in a result register until downstream accepts it.
module booth_feeder
  import booth_feeder_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_a,
  input  logic [WIDTH-1:0]       in_b,
  output logic                   mul_en,
  output logic [WIDTH-1:0]       mul_a,
  output logic [WIDTH-1:0]       mul_b,
  input  logic                   mul_done,
  input  logic [2*WIDTH-1:0]     mul_m,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*WIDTH-1:0]     out_m,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [7:0]             result_cnt
);

  localparam int unsigned PW = 2 * WIDTH;

  state_e           state_q, state_d;
  logic             mul_en_q, mul_en_d;
  logic [WIDTH-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic             out_valid_q, out_valid_d;
  logic [PW-1:0]    out_m_q, out_m_d;
  logic [7:0]       result_cnt_q, result_cnt_d;
  logic             fifo_pop_c;
  logic [PW-1:0]    fifo_head_c;

  op_fifo #(
    .DW    (PW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (in_valid),
    .pop_i   (fifo_pop_c),
    .wdata_i ({in_a, in_b}),
    .head_c  (fifo_head_c),
    .count_o (fifo_count),
    .ready_o (in_ready)
  );

  // Next-state and registered-output logic; mul_done only matters in ISSUE.
  always_comb begin
    state_d      = state_q;
    mul_en_d     = mul_en_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    out_valid_d  = out_valid_q;
    out_m_d      = out_m_q;
    result_cnt_d = result_cnt_q;
    fifo_pop_c   = 1'b0;

    if (out_valid_q && out_ready) begin
      out_valid_d  = 1'b0;
      result_cnt_d = result_cnt_q + 8'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if ((fifo_count != '0) && !out_valid_q) begin
          state_d  = ST_ISSUE;
          mul_en_d = 1'b1;
          mul_a_d  = fifo_head_c[PW-1:WIDTH];
          mul_b_d  = fifo_head_c[WIDTH-1:0];
        end
      end
      ST_ISSUE: begin
        if (mul_done) begin
          state_d     = ST_RELEASE;
          mul_en_d    = 1'b0;
          out_m_d     = mul_m;
          out_valid_d = 1'b1;
          fifo_pop_c  = 1'b1;
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        mul_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      mul_en_q     <= 1'b0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      out_valid_q  <= 1'b0;
      out_m_q      <= '0;
      result_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      mul_en_q     <= mul_en_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      out_valid_q  <= out_valid_d;
      out_m_q      <= out_m_d;
      result_cnt_q <= result_cnt_d;
    end
  end

  assign mul_en     = mul_en_q;
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign out_valid  = out_valid_q;
  assign out_m      = out_m_q;
  assign result_cnt = result_cnt_q;

endmodule

// File: doc/booth_feeder.md
BOOTH_FEEDER -- requirements
Module: booth_feeder

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits shared with booth_mult.
REQ-002 Parameter DEPTH, default 4, operand FIFO depth; SHALL be a power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  upstream operand pair valid.
REQ-006 in_ready  output  1  FIFO can accept a pair this cycle.
REQ-007 in_a, in_b  input  WIDTH each  signed operands.
REQ-008 mul_en  output  1  enable to booth_mult.
REQ-009 mul_a, mul_b  output  WIDTH each  signed operands to booth_mult.
REQ-010 mul_done  input  1  booth_mult completion.
REQ-011 mul_m  input  2*WIDTH  signed product from booth_mult.
REQ-012 out_valid  output  1  result register holds a product.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 out_m  output  2*WIDTH  signed product.
REQ-015 fifo_count  output  $clog2(DEPTH)+1  pairs currently queued.
REQ-016 result_cnt  output  8  number of results accepted downstream; wraps modulo 256.

Function
REQ-017 FIFO push: on in_valid && in_ready. in_ready = (fifo_count < DEPTH), registered only, with no combinational path from out_ready or mul_done.
REQ-018 FIFO pop: on the cycle mul_done is sampled high in ISSUE. Push and pop in the same cycle leave fifo_count unchanged.
REQ-019 Read and write pointers wrap modulo DEPTH. Entries leave the FIFO in push order.
REQ-020 FSM has three states: IDLE, ISSUE, RELEASE.
REQ-021 IDLE -> ISSUE when fifo_count != 0 and out_valid == 0. Otherwise the FSM stays in IDLE.
REQ-022 In ISSUE: mul_en = 1, and mul_a/mul_b equal the FIFO head, held stable until mul_done.
REQ-023 ISSUE -> RELEASE on mul_done. In that cycle: mul_m is captured into out_m, out_valid is set the next cycle, and the head is popped.
REQ-024 In RELEASE: mul_en = 0 for exactly one cycle, then the FSM returns to IDLE.
REQ-025 mul_en is 0 in IDLE and RELEASE, so every operation sees an en low-to-high edge.
REQ-026 mul_done is ignored outside ISSUE.
REQ-027 out_valid clears on out_valid && out_ready. result_cnt increments on the same cycle.
REQ-028 out_m and out_valid are held stable while out_valid && !out_ready.
REQ-029 Minimum issue interval: operation latency + 2 cycles (RELEASE + IDLE). This requires out_ready high on the out_valid cycle.
REQ-030 No arithmetic on the product: out_m is a bit-exact copy of mul_m.
REQ-031 A FIFO full with a held result: in_ready = 0 and the FSM waits in IDLE. No data is lost or duplicated.

Reset
REQ-032 While rst_n is low, the following hold: state = IDLE, pointers = 0, fifo_count = 0, in_ready = 1 after release, mul_en = 0, mul_a = mul_b = 0, out_valid = 0, out_m = 0, result_cnt = 0.
REQ-033 Reset asserted mid-ISSUE: mul_en drops asynchronously, and the in-flight pair and queued pairs are discarded.
REQ-034 FIFO storage array needs no reset.

Structure
REQ-035 Shared package: FSM state encoding (IDLE=2'd0, ISSUE=2'd1, RELEASE=2'd2) and the default WIDTH/DEPTH constants.
REQ-036 One sub-module, op_fifo (parameterised WIDTH*2 data, DEPTH), instantiated once. The FSM and result register live in booth_feeder.

Verification
REQ-037 Bench connects booth_feeder to booth_mult with WIDTH=8. Clock period 20, rst_n released at t=10.
REQ-038 Single pairs pushed one at a time: (1,1), (1,-1), (-1,-1), (-10,-100), (10,-5), (5,8) -> out_m = 1, -1, 1, 1000, -50, 40 in order.
REQ-039 Burst of 4 back-to-back pushes: (-128,-128), (-128,127), (100,127), (3,3). Expect in_ready = 0 after the 4th push, then out_m = 16384, -16256, 12700, 9, and result_cnt = 4.
REQ-040 out_ready held low for 50 cycles after the first result. Expect out_m stable and mul_en = 0 throughout, FIFO fills to DEPTH, and no result is lost after release.
REQ-041 rst_n pulsed low while in ISSUE with 3 pairs queued. Expect mul_en = 0, fifo_count = 0 and out_valid = 0 immediately, and correct products for new pairs afterwards.
REQ-042 Assertions throughout: mul_a/mul_b stable while mul_en = 1; mul_en low at least 1 cycle between operations; and a push on the same cycle as a pop keeps fifo_count constant.
